// File: rtl/wm8731_audio_pkg.sv
// rtl/wm8731_audio_pkg.sv - shared audio-side state encoding and default constants
package wm8731_audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SYNC  = 2'd2,
    ST_RUN   = 2'd3
  } audio_state_e;

  localparam int XCK_DIV_DEF   = 4;
  localparam int BCLK_DIV_DEF  = 16;
  localparam int SLOT_BITS_DEF = 32;
  localparam int SAMPLE_W_DEF  = 24;

endpackage

// File: rtl/wm8731_adc_capture_if.sv
// rtl/wm8731_adc_capture_if.sv - stereo sample pair valid/ready interface
interface wm8731_adc_capture_if
  import wm8731_audio_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
);
  logic [SAMPLE_W-1:0] sample_l;
  logic [SAMPLE_W-1:0] sample_r;
  logic                sample_valid;
  logic                sample_ready;

  modport master (output sample_l, output sample_r, output sample_valid, input sample_ready);
  modport slave  (input sample_l, input sample_r, input sample_valid, output sample_ready);
endinterface

// File: rtl/wm8731_audio_clkgen.sv
// rtl/wm8731_audio_clkgen.sv - codec XCK/BCLK/LRCK generation with slot bit index and sample strobe
module wm8731_audio_clkgen
  import wm8731_audio_pkg::*;
#(
  parameter int XCK_DIV   = XCK_DIV_DEF,
  parameter int BCLK_DIV  = BCLK_DIV_DEF,
  parameter int SLOT_BITS = SLOT_BITS_DEF,
  localparam int FRAME_W  = $clog2(2*SLOT_BITS)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  output logic               o_xck,
  output logic               o_bclk,
  output logic               o_lrck,
  output logic               o_strobe,
  output logic               o_left,
  output logic               o_frame_last,
  output logic [FRAME_W-1:0] o_bit_idx
);
  localparam int XCK_W  = $clog2(XCK_DIV);
  localparam int BCLK_W = $clog2(BCLK_DIV);

  logic [XCK_W-1:0]   r_xck_cnt, w_xck_nxt;
  logic [BCLK_W-1:0]  r_bclk_cnt, w_bclk_nxt;
  logic [FRAME_W-1:0] r_frame_cnt, w_frame_nxt;
  logic               r_active;
  logic               r_xck, r_bclk, r_lrck;

  // First enabled cycle starts every counter at 0; clock levels follow the next count.
  always_comb begin
    w_xck_nxt   = '0;
    w_bclk_nxt  = '0;
    w_frame_nxt = '0;
    if (r_active) begin
      w_xck_nxt   = (r_xck_cnt == XCK_W'(XCK_DIV-1)) ? '0 : r_xck_cnt + 1'b1;
      w_bclk_nxt  = (r_bclk_cnt == BCLK_W'(BCLK_DIV-1)) ? '0 : r_bclk_cnt + 1'b1;
      w_frame_nxt = r_frame_cnt;
      if (r_bclk_cnt == BCLK_W'(BCLK_DIV-1))
        w_frame_nxt = (r_frame_cnt == FRAME_W'(2*SLOT_BITS-1)) ? '0 : r_frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active    <= 1'b0;
      r_xck_cnt   <= '0;
      r_bclk_cnt  <= '0;
      r_frame_cnt <= '0;
      r_xck       <= 1'b0;
      r_bclk      <= 1'b0;
      r_lrck      <= 1'b0;
    end else if (!i_en) begin
      r_active    <= 1'b0;
      r_xck_cnt   <= '0;
      r_bclk_cnt  <= '0;
      r_frame_cnt <= '0;
      r_xck       <= 1'b0;
      r_bclk      <= 1'b0;
      r_lrck      <= 1'b0;
    end else begin
      r_active    <= 1'b1;
      r_xck_cnt   <= w_xck_nxt;
      r_bclk_cnt  <= w_bclk_nxt;
      r_frame_cnt <= w_frame_nxt;
      r_xck       <= (w_xck_nxt < XCK_W'(XCK_DIV/2));
      r_bclk      <= (w_bclk_nxt >= BCLK_W'(BCLK_DIV/2));
      r_lrck      <= (w_frame_nxt < FRAME_W'(SLOT_BITS));
    end
  end

  assign o_xck        = r_xck;
  assign o_bclk       = r_bclk;
  assign o_lrck       = r_lrck;
  assign o_strobe     = r_active && (r_bclk_cnt == BCLK_W'(BCLK_DIV-1));
  assign o_frame_last = o_strobe && (r_frame_cnt == FRAME_W'(2*SLOT_BITS-1));
  assign o_left       = (r_frame_cnt < FRAME_W'(SLOT_BITS));
  assign o_bit_idx    = o_left ? r_frame_cnt : r_frame_cnt - FRAME_W'(SLOT_BITS);

endmodule

// File: rtl/wm8731_adc_capture.sv
// rtl/wm8731_adc_capture.sv - WM8731 I2S ADC capture: arming FSM, deserialiser, sample pair handshake
// Optional ADC_CAPTURE_STATS_EN adds o_overrun_cnt and o_frame_err.
module wm8731_adc_capture
  import wm8731_audio_pkg::*;
#(
  parameter int XCK_DIV   = XCK_DIV_DEF,
  parameter int BCLK_DIV  = BCLK_DIV_DEF,
  parameter int SLOT_BITS = SLOT_BITS_DEF,
  parameter int SAMPLE_W  = SAMPLE_W_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cfg_done,
  input  logic        i_aud_adcdat,
  output logic        o_aud_xck,
  output logic        o_aud_bclk,
  output logic        o_aud_adclrck,
  output logic        o_overrun,
`ifdef ADC_CAPTURE_STATS_EN
  output logic [15:0] o_overrun_cnt,
  output logic        o_frame_err,
`endif
  wm8731_adc_capture_if.master o_sample
);
  localparam int FRAME_W = $clog2(2*SLOT_BITS);

  audio_state_e       r_state, w_state_nxt;
  logic               w_clk_en, w_run;
  logic               w_strobe, w_left, w_frame_last;
  logic [FRAME_W-1:0] w_bit_idx;

  logic [SAMPLE_W-1:0] r_shift_l, r_shift_r, r_sample_l, r_sample_r;
  logic                r_valid, r_done, r_overrun;
  logic                w_ready;

  assign w_ready = o_sample.sample_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Config must be seen busy then done, so the reset-high END_TR never arms the block.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (!i_cfg_done) w_state_nxt = ST_ARMED;
      ST_ARMED: if (i_cfg_done)  w_state_nxt = ST_SYNC;
      ST_SYNC:  if (!i_cfg_done) w_state_nxt = ST_IDLE;
                else if (w_frame_last) w_state_nxt = ST_RUN;
      ST_RUN:   if (!i_cfg_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_clk_en = (w_state_nxt == ST_SYNC) || (w_state_nxt == ST_RUN);
    w_run    = (r_state == ST_RUN);
  end

  wm8731_audio_clkgen #(
    .XCK_DIV  (XCK_DIV),
    .BCLK_DIV (BCLK_DIV),
    .SLOT_BITS(SLOT_BITS)
  ) u_clkgen (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (w_clk_en),
    .o_xck       (o_aud_xck),
    .o_bclk      (o_aud_bclk),
    .o_lrck      (o_aud_adclrck),
    .o_strobe    (w_strobe),
    .o_left      (w_left),
    .o_frame_last(w_frame_last),
    .o_bit_idx   (w_bit_idx)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift_l <= '0;
      r_shift_r <= '0;
      r_done    <= 1'b0;
    end else begin
      if (w_run && w_strobe && (w_bit_idx < FRAME_W'(SAMPLE_W))) begin
        if (w_left) r_shift_l <= {r_shift_l[SAMPLE_W-2:0], i_aud_adcdat};
        else        r_shift_r <= {r_shift_r[SAMPLE_W-2:0], i_aud_adcdat};
      end
      r_done <= w_run && w_strobe && !w_left && (w_bit_idx == FRAME_W'(SAMPLE_W-1));
    end
  end

  // A completed pair replaces the held one only if it is free or leaving this cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sample_l <= '0;
      r_sample_r <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_done && (!r_valid || w_ready)) begin
        r_sample_l <= r_shift_l;
        r_sample_r <= r_shift_r;
        r_valid    <= 1'b1;
      end else begin
        if (r_done)              r_overrun <= 1'b1;
        if (r_valid && w_ready)  r_valid   <= 1'b0;
      end
    end
  end

`ifdef ADC_CAPTURE_STATS_EN
  logic [15:0] r_overrun_cnt;
  logic        r_frame_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overrun_cnt <= '0;
      r_frame_err   <= 1'b0;
    end else begin
      if (r_overrun && (r_overrun_cnt != 16'hFFFF)) r_overrun_cnt <= r_overrun_cnt + 16'd1;
      if (w_run && !i_cfg_done) r_frame_err <= 1'b1;
    end
  end

  assign o_overrun_cnt = r_overrun_cnt;
  assign o_frame_err   = r_frame_err;
`endif

  assign o_overrun             = r_overrun;
  assign o_sample.sample_l     = r_sample_l;
  assign o_sample.sample_r     = r_sample_r;
  assign o_sample.sample_valid = r_valid;

endmodule

// File: tb/tb_wm8731_adc_capture.sv
// tb/tb_wm8731_adc_capture.sv - directed/random bench for wm8731_adc_capture with a codec model
module tb_wm8731_adc_capture;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_done = 1'b1;
  logic adcdat = 1'b0;
  logic ready = 1'b0;
  logic xck, bclk, lrck, ovr;
`ifdef ADC_CAPTURE_STATS_EN
  logic [15:0] ovr_cnt;
  logic        ferr;
`endif

  always #5 clk = ~clk;

  wm8731_adc_capture_if #(.SAMPLE_W(24)) smp ();
  assign smp.sample_ready = ready;

  wm8731_adc_capture dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cfg_done   (cfg_done),
    .i_aud_adcdat (adcdat),
    .o_aud_xck    (xck),
    .o_aud_bclk   (bclk),
    .o_aud_adclrck(lrck),
    .o_overrun    (ovr),
`ifdef ADC_CAPTURE_STATS_EN
    .o_overrun_cnt(ovr_cnt),
    .o_frame_err  (ferr),
`endif
    .o_sample     (smp)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int ovr_seen = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (ovr === 1'b1) ovr_seen++;

  // Codec model: left-justified 24-bit words, new word each left slot, data changes on BCLK fall
  int          mode = 1;
  logic [23:0] sent_l [1024];
  logic [23:0] sent_r [1024];
  int          sent_wr = 0;
  logic [23:0] cur_l = '0, cur_r = '0, ramp_n = 24'd1;
  int          m_bit = 0;
  logic        m_lrck_q = 1'b0, m_bclk_q = 1'b0;

  always @(negedge clk) begin
    if (lrck && !m_lrck_q) begin
      case (mode)
        1:       begin cur_l = 24'h123456; cur_r = 24'hFEDCBA; end
        2:       begin cur_l = ramp_n; cur_r = 24'd0 - ramp_n; ramp_n = ramp_n + 24'd1; end
        default: begin cur_l = 24'($urandom); cur_r = 24'($urandom); end
      endcase
      sent_l[sent_wr % 1024] = cur_l;
      sent_r[sent_wr % 1024] = cur_r;
      sent_wr++;
      m_bit = 0;
    end else if (lrck != m_lrck_q) begin
      m_bit = 0;
    end else if (m_bclk_q && !bclk) begin
      m_bit++;
    end
    if (m_bit < 24) adcdat = lrck ? cur_l[23-m_bit] : cur_r[23-m_bit];
    else            adcdat = 1'($urandom_range(0, 1));
    m_lrck_q = lrck;
    m_bclk_q = bclk;
  end

  int rd = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reconfiguration: busy then done; a pair completing while clocks stop is drained.
  task automatic arm();
    logic keep;
    keep = ready;
    cfg_done = 1'b0;
    ready = 1'b1;
    cycles(4);
    ready = keep;
    rd = (sent_wr + 1) % 1024;
    cfg_done = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit got, output logic [23:0] l,
                            output logic [23:0] r, output int t);
    got = 1'b0; l = '0; r = '0; t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (smp.sample_valid === 1'b1) begin
        got = 1'b1; l = smp.sample_l; r = smp.sample_r; t = cyc;
        break;
      end
    end
  endtask

  task automatic edge_time(input bit use_lrck, input bit rising, output int t);
    logic prev, now;
    t = -1;
    prev = use_lrck ? lrck : bclk;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      now = use_lrck ? lrck : bclk;
      if (now != prev && now == rising) begin t = cyc; break; end
      prev = now;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    logic [23:0] l, r, l0, r0, prev_l;
    int          t, t_prev, a, b, bad, ovr0;

    cycles(3);
    check("reset_outputs", {xck, bclk, lrck, smp.sample_valid, ovr, smp.sample_l, smp.sample_r}, 0);
    rst_n = 1'b1;

    bad = 0;
    repeat (5000) begin
      @(negedge clk);
      if (xck !== 1'b0 || bclk !== 1'b0 || lrck !== 1'b0 || smp.sample_valid !== 1'b0) bad++;
    end
    check("idle_no_arm", bad, 0);

    mode = 1;
    ready = 1'b0;
    arm();
    wait_valid(4000, got, l, r, t);
    check("fixed_got", got, 1);
    check("fixed_left", l, 24'h123456);
    check("fixed_right", r, 24'hFEDCBA);
    edge_time(1'b0, 1'b1, a);
    edge_time(1'b0, 1'b1, b);
    check("bclk_period", b - a, 16);
    edge_time(1'b1, 1'b1, a);
    edge_time(1'b1, 1'b1, b);
    check("lrck_period", b - a, 1024);

    mode = 2;
    ready = 1'b1;
    arm();
    ovr0 = ovr_seen;
    prev_l = '0;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_valid(2500, got, l, r, t);
      check("ramp_got", got, 1);
      check("ramp_pair", {l, r}, {sent_l[rd], sent_r[rd]});
      if (i > 0) begin
        check("ramp_order", l, prev_l + 24'd1);
        check("ramp_interval", t - t_prev, 1024);
      end
      rd = (rd + 1) % 1024;
      prev_l = l;
      t_prev = t;
    end
    check("ramp_no_overrun", ovr_seen - ovr0, 0);

    mode = 0;
    arm();
    for (int i = 0; i < 3; i++) begin
      wait_valid(2500, got, l, r, t);
      check("rand_got", got, 1);
      check("rand_pair", {l, r}, {sent_l[rd], sent_r[rd]});
      rd = (rd + 1) % 1024;
    end

    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    ready = 1'b0;
    arm();
    wait_valid(4000, got, l0, r0, t);
    check("hold_got", got, 1);
    check("hold_pair", {l0, r0}, {sent_l[rd], sent_r[rd]});
    ovr0 = ovr_seen;
    bad = 0;
    repeat (2100) begin
      @(negedge clk);
      if (smp.sample_valid !== 1'b1 || smp.sample_l !== l0 || smp.sample_r !== r0) bad++;
    end
    check("hold_stable", bad, 0);
    check("hold_overruns", ovr_seen - ovr0, 2);
`ifdef ADC_CAPTURE_STATS_EN
    check("overrun_cnt", ovr_cnt, 16'd2);
`endif
    ready = 1'b1;
    cycles(3);
    check("valid_drop", smp.sample_valid, 1'b0);

    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    mode = 0;
    arm();
    wait_valid(4000, got, l, r, t);
    check("pre_drop_pair", {got, l, r}, {1'b1, sent_l[rd], sent_r[rd]});
`ifdef ADC_CAPTURE_STATS_EN
    check("frame_err_clear", ferr, 1'b0);
`endif
    edge_time(1'b1, 1'b1, a);
    cycles(200);
    cfg_done = 1'b0;
    @(negedge clk);
    check("drop_clocks_low", {xck, bclk, lrck}, 3'b000);
    bad = 0;
    repeat (1500) begin
      @(negedge clk);
      if (smp.sample_valid !== 1'b0) bad++;
    end
    check("drop_no_pair", bad, 0);
`ifdef ADC_CAPTURE_STATS_EN
    check("frame_err_set", ferr, 1'b1);
`endif
    arm();
    wait_valid(4000, got, l, r, t);
    check("rearm_pair", {got, l, r}, {1'b1, sent_l[rd], sent_r[rd]});

    edge_time(1'b1, 1'b0, a);
    cycles(300);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {xck, bclk, lrck, smp.sample_valid, ovr, smp.sample_l, smp.sample_r}, 0);
`ifdef ADC_CAPTURE_STATS_EN
    check("async_reset_stats", {ovr_cnt, ferr}, 0);
`endif
    cycles(3);
    rst_n = 1'b1;
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (smp.sample_valid !== 1'b0 || ovr !== 1'b0 || bclk !== 1'b0) bad++;
    end
    check("post_reset_quiet", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
